// File: rtl/font_render_ctrl_if.sv
// Character request and glyph column byte streams
// between the text formatter, font sequencer and LCD writer.
interface font_render_ctrl_if;
  logic       in_valid;
  logic [7:0] in_code;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  modport master (
    output in_valid,
    output in_code,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_code,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/font_render_ctrl.sv
// Font ROM sequencer: maps a character code to its glyph,
// reads one ROM byte per column and streams the columns out.
module font_render_ctrl #(
  parameter int unsigned GLYPH_W    = 5,
  parameter logic [7:0]  FIRST_CHAR = 8'h20,
  parameter logic [7:0]  LAST_CHAR  = 8'h7F,
  parameter logic [7:0]  SUB_CHAR   = 8'h3F,
  parameter int unsigned ROM_LAT    = 1,
  parameter bit          SPACER     = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  font_render_ctrl_if.slave   bus,
  output logic                rom_rd,
  output logic [9:0]          rom_addr,
  input  logic [7:0]          rom_data,
  output logic                busy,
  output logic                err_char
);

  localparam int unsigned CLW =
    (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned CW =
    (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CLW-1:0] COL_END =
    CLW'(GLYPH_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PUSH,
    PAD
  } state_t;

  state_t         state;
  logic [CLW-1:0] col;
  logic [CW-1:0]  cnt;
  logic [9:0]     base;

  logic           oor;
  logic [7:0]     code_m;
  logic [9:0]     base_n;

  always_comb begin
    oor    = (bus.in_code < FIRST_CHAR) ||
             (bus.in_code > LAST_CHAR);
    code_m = oor ? SUB_CHAR : bus.in_code;
    base_n = 10'(10'(code_m) - 10'(FIRST_CHAR))
           * 10'(GLYPH_W);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      col           <= '0;
      cnt           <= '0;
      base          <= '0;
      rom_rd        <= 1'b0;
      rom_addr      <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      busy          <= 1'b0;
      err_char      <= 1'b0;
    end else begin
      err_char <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            base         <= base_n;
            col          <= '0;
            rom_addr     <= base_n;
            rom_rd       <= 1'b1;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            err_char     <= oor;
            state        <= FETCH;
          end
        end
        FETCH: begin
          rom_rd <= 1'b0;
          cnt    <= CW'(ROM_LAT - 1);
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            bus.out_data  <= rom_data;
            bus.out_valid <= 1'b1;
            bus.out_last  <= !SPACER &&
                             (col == COL_END);
            state         <= PUSH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PUSH: begin
          if (bus.out_ready) begin
            if (col == COL_END) begin
              if (SPACER) begin
                bus.out_data <= '0;
                bus.out_last <= 1'b1;
                state        <= PAD;
              end else begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
                bus.in_ready  <= 1'b1;
                busy          <= 1'b0;
                state         <= IDLE;
              end
            end else begin
              col           <= col + 1'b1;
              rom_addr      <= base + 10'(col) + 10'd1;
              rom_rd        <= 1'b1;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              state         <= FETCH;
            end
          end
        end
        PAD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_font_render_ctrl.sv
// Bench for font_render_ctrl: default build and a
// no-spacer, two-cycle-ROM build against a glyph-level model.
module tb_font_render_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  font_render_ctrl_if b0 ();
  font_render_ctrl_if b1 ();

  logic       rd0, rd1, busy0, busy1, err0, err1;
  logic [9:0] addr0, addr1;
  logic [7:0] rdat0, rdat1;
  logic [7:0] p0 = 8'hEE, p1a = 8'hEE, p1b = 8'hEE;

  font_render_ctrl u0 (
    .clk(clk), .reset(reset), .bus(b0.slave),
    .rom_rd(rd0), .rom_addr(addr0), .rom_data(rdat0),
    .busy(busy0), .err_char(err0)
  );

  font_render_ctrl #(.ROM_LAT(2), .SPACER(1'b0)) u1 (
    .clk(clk), .reset(reset), .bus(b1.slave),
    .rom_rd(rd1), .rom_addr(addr1), .rom_data(rdat1),
    .busy(busy1), .err_char(err1)
  );

  function automatic logic [7:0] rom_fn(input logic [9:0] a);
    return 8'(a * 10'd37) ^ 8'(a >> 3) ^ 8'h5A;
  endfunction

  // ROM data appears ROM_LAT cycles after the strobe; junk otherwise
  always @(posedge clk) begin
    p0  <= rd0 ? rom_fn(addr0) : 8'hEE;
    p1a <= rd1 ? rom_fn(addr1) : 8'hEE;
    p1b <= p1a;
  end
  assign rdat0 = p0;
  assign rdat1 = p1b;

  logic       sel = 1'b0;
  logic       m_rd, m_iv, m_ir, m_ov, m_or, m_ol, m_err, m_busy;
  logic [9:0] m_addr;
  logic [7:0] m_od, m_code;

  assign m_rd   = sel ? rd1 : rd0;
  assign m_addr = sel ? addr1 : addr0;
  assign m_err  = sel ? err1 : err0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_iv   = sel ? b1.in_valid : b0.in_valid;
  assign m_code = sel ? b1.in_code : b0.in_code;
  assign m_ir   = sel ? b1.in_ready : b0.in_ready;
  assign m_ov   = sel ? b1.out_valid : b0.out_valid;
  assign m_or   = sel ? b1.out_ready : b0.out_ready;
  assign m_od   = sel ? b1.out_data : b0.out_data;
  assign m_ol   = sel ? b1.out_last : b0.out_last;

  logic [9:0] rd_q[$];
  int         rdc_q[$];
  logic [7:0] acc_q[$];
  int         accc_q[$];
  int         errc_q[$];
  logic [8:0] out_q[$];
  int         lastc_q[$];
  int         stall_rd, stall_cyc, unstable;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic       prev_l;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (m_rd) begin
        rd_q.push_back(m_addr);
        rdc_q.push_back(cyc);
        if (m_ov && !m_or) stall_rd++;
      end
      if (m_iv && m_ir) begin
        acc_q.push_back(m_code);
        accc_q.push_back(cyc);
      end
      if (m_err) errc_q.push_back(cyc);
      if (m_ov && m_or) begin
        out_q.push_back({m_ol, m_od});
        if (m_ol) lastc_q.push_back(cyc);
      end
      if (m_ov && !m_or) stall_cyc++;
      if (prev_stall &&
          (m_od !== prev_d || m_ol !== prev_l || !m_ov))
        unstable++;
      prev_stall = m_ov && !m_or;
      prev_d = m_od;
      prev_l = m_ol;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive_in(input logic v, input logic [7:0] c);
    b0.in_valid = v & !sel;
    b1.in_valid = v & sel;
    b0.in_code = c;
    b1.in_code = c;
  endtask

  task automatic set_ready(input logic r);
    b0.out_ready = r;
    b1.out_ready = r;
  endtask

  task automatic clear_mon();
    rd_q.delete(); rdc_q.delete();
    acc_q.delete(); accc_q.delete();
    errc_q.delete(); out_q.delete();
    lastc_q.delete();
    stall_rd = 0; stall_cyc = 0; unstable = 0;
  endtask

  task automatic wait_idle(input int mode);
    int budget = 0;
    int stall_left = 7;
    while (!m_ir && budget < 400) begin
      if (mode == 1)
        set_ready($urandom_range(0, 3) != 0);
      else if (mode == 2 && out_q.size() == 2 &&
               m_ov && stall_left > 0) begin
        set_ready(1'b0);
        stall_left--;
      end else
        set_ready(1'b1);
      @(posedge clk); #1;
      budget++;
    end
    set_ready(1'b1);
    chk("idle_timeout", 32'(budget < 400), 32'd1);
  endtask

  task automatic send(input logic [7:0] code);
    int budget = 0;
    drive_in(1'b1, code);
    while (accc_q.size() == 0 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    drive_in(1'b0, code);
    chk("accept", 32'(accc_q.size()), 32'd1);
  endtask

  task automatic verify(input logic [7:0] code, input int mode);
    logic [7:0] m;
    logic       oor;
    int         lat, a;
    logic [8:0] exp_q[$];
    oor = (code < 8'h20) || (code > 8'h7F);
    m = oor ? 8'h3F : code;
    lat = sel ? 2 : 1;
    for (int c = 0; c < 5; c++) begin
      a = (int'(m) - 32) * 5 + c;
      exp_q.push_back({sel && c == 4, rom_fn(10'(a))});
    end
    if (!sel) exp_q.push_back(9'h100);
    chk("rd_count", 32'(rd_q.size()), 32'd5);
    for (int c = 0; c < rd_q.size() && c < 5; c++)
      chk($sformatf("addr%0d", c), 32'(rd_q[c]),
          32'((int'(m) - 32) * 5 + c));
    chk("byte_count", 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      chk($sformatf("byte%0d", i), 32'(out_q[i]),
          32'(exp_q[i]));
    chk("err_count", 32'(errc_q.size()), 32'(oor));
    if (errc_q.size() > 0 && accc_q.size() > 0)
      chk("err_time", 32'(errc_q[0]), 32'(accc_q[0] + 1));
    if (rdc_q.size() > 0 && accc_q.size() > 0)
      chk("first_rd", 32'(rdc_q[0]), 32'(accc_q[0] + 1));
    if (mode == 0 && rdc_q.size() > 1)
      chk("col_gap", 32'(rdc_q[1] - rdc_q[0]), 32'(2 + lat));
    if (mode == 2) begin
      chk("stall_cycles", 32'(stall_cyc), 32'd7);
      chk("stall_rd", 32'(stall_rd), 32'd0);
      chk("stall_stable", 32'(unstable), 32'd0);
    end
  endtask

  task automatic glyph(input logic [7:0] code, input int mode);
    clear_mon();
    send(code);
    wait_idle(mode);
    verify(code, mode);
  endtask

  initial begin
    int budget;
    b0.in_valid = 1'b0; b0.in_code = '0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_code = '0; b1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(b0.in_ready), 32'd1);
    chk("rst_rom_rd", 32'(rd0), 32'd0);
    chk("rst_rom_addr", 32'(addr0), 32'd0);
    chk("rst_out_valid", 32'(b0.out_valid), 32'd0);
    chk("rst_out_data", 32'(b0.out_data), 32'd0);
    chk("rst_out_last", 32'(b0.out_last), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_in_ready1", 32'(b1.in_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    glyph(8'h41, 0);
    glyph(8'h10, 0);
    glyph(8'h7F, 0);
    glyph(8'h80, 0);
    glyph(8'h41, 2);

    // abort mid-glyph: column 3 fetched, now waiting on the ROM
    clear_mon();
    send(8'h41);
    set_ready(1'b1);
    budget = 0;
    while (rd_q.size() < 4 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("reach_col3", 32'(rd_q.size()), 32'd4);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_out_valid", 32'(b0.out_valid), 32'd0);
    chk("abort_rom_rd", 32'(rd0), 32'd0);
    chk("abort_in_ready", 32'(b0.in_ready), 32'd1);
    chk("abort_busy", 32'(busy0), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    glyph(8'h55, 0);

    // back-to-back requests with valid held throughout
    clear_mon();
    drive_in(1'b1, 8'h30);
    budget = 0;
    while (accc_q.size() < 1 && budget < 50) begin
      @(posedge clk); #1; budget++;
    end
    drive_in(1'b1, 8'h31);
    budget = 0;
    while (accc_q.size() < 2 && budget < 100) begin
      @(posedge clk); #1; budget++;
    end
    drive_in(1'b0, 8'h31);
    wait_idle(0);
    chk("b2b_accepts", 32'(acc_q.size()), 32'd2);
    chk("b2b_bytes", 32'(out_q.size()), 32'd12);
    chk("b2b_reads", 32'(rd_q.size()), 32'd10);
    if (acc_q.size() == 2 && lastc_q.size() > 0) begin
      chk("b2b_code0", 32'(acc_q[0]), 32'h30);
      chk("b2b_code1", 32'(acc_q[1]), 32'h31);
      chk("b2b_order", 32'(accc_q[1] > lastc_q[0]), 32'd1);
    end
    if (rd_q.size() > 5)
      chk("b2b_addr5", 32'(rd_q[5]), 32'd85);

    for (int i = 0; i < 6; i++)
      glyph(8'($urandom_range(0, 255)), 1);

    sel = 1'b1;
    @(posedge clk); #1;
    glyph(8'h41, 0);
    glyph(8'h10, 0);
    glyph(8'h7F, 0);
    glyph(8'h41, 2);
    for (int i = 0; i < 4; i++)
      glyph(8'($urandom_range(0, 255)), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
